// File: rtl/data_compare_seq_pkg.sv
// Shared definitions for the sequential magnitude comparator:
// result/cascade codes, FSM state encoding and cascade-in resolution.
package data_compare_seq_pkg;

    // One-hot result / cascade codes {gt, eq, lt}
    localparam logic [2:0] CMP_GT = 3'b100;
    localparam logic [2:0] CMP_EQ = 3'b010;
    localparam logic [2:0] CMP_LT = 3'b001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Resolve a (possibly illegal) cascade-in code; eq > gt > lt priority,
    // and an all-zero code counts as equal.
    function automatic logic [2:0] resolve_cascade(input logic [2:0] casc);
        logic [2:0] res;
        if (casc[1] || (casc == 3'b000)) begin
            res = CMP_EQ;
        end else if (casc[2]) begin
            res = CMP_GT;
        end else begin
            res = CMP_LT;
        end
        return res;
    endfunction

endpackage

// File: rtl/data_compare_seq_if.sv
// Handshake/operand bundle for data_compare_seq.
//   iStart, iSigned, iData_a, iData_b, iData : request side (master drives)
//   oData, oBusy, oDone                      : result side (slave drives)
interface data_compare_seq_if #(
    parameter int unsigned WIDTH = 16
);
    logic             iStart;
    logic             iSigned;
    logic [WIDTH-1:0] iData_a;
    logic [WIDTH-1:0] iData_b;
    logic [2:0]       iData;
    logic [2:0]       oData;
    logic             oBusy;
    logic             oDone;

    modport master (
        output iStart, iSigned, iData_a, iData_b, iData,
        input  oData, oBusy, oDone
    );

    modport slave (
        input  iStart, iSigned, iData_a, iData_b, iData,
        output oData, oBusy, oDone
    );
endinterface

// File: rtl/data_compare_seq_slice.sv
// Purely combinational SLICE-bit unsigned comparator; eq is implied by
// neither gt nor lt.
//   a_i, b_i : slice operands
//   gt_o     : a_i > b_i
//   lt_o     : a_i < b_i
module data_compare_seq_slice #(
    parameter int unsigned SLICE = 4
) (
    input  logic [SLICE-1:0] a_i,
    input  logic [SLICE-1:0] b_i,
    output logic             gt_o,
    output logic             lt_o
);
    assign gt_o = (a_i > b_i);
    assign lt_o = (a_i < b_i);
endmodule

// File: rtl/data_compare_seq.sv
// Multi-cycle magnitude comparator: walks the operands one SLICE-bit slice
// per clock, MSB slice first, exiting early on the first differing slice.
//   iClk, iRst_n : clock, asynchronous active-low reset
//   bus          : slave side of data_compare_seq_if (start/operands in,
//                  one-hot result, busy and done pulse out; all registered)
module data_compare_seq
    import data_compare_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SLICE = 4
) (
    input  logic                iClk,
    input  logic                iRst_n,
    data_compare_seq_if.slave   bus
);

    localparam int unsigned NSL   = WIDTH / SLICE;
    localparam int unsigned CNT_W = (NSL > 1) ? $clog2(NSL) : 1;
    localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

    if ((WIDTH % SLICE) != 0 || SLICE < 1) begin : g_bad_width
        $error("data_compare_seq: WIDTH must be a non-zero multiple of SLICE");
    end

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [2:0]       casc_q, casc_d;
    logic [2:0]       data_q, data_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [SLICE-1:0] slice_a, slice_b;
    logic             slice_gt, slice_lt;

    // Single slice comparator, muxed by the counter
    assign slice_a = a_q[cnt_q * SLICE +: SLICE];
    assign slice_b = b_q[cnt_q * SLICE +: SLICE];

    data_compare_seq_slice #(.SLICE(SLICE)) u_slice (
        .a_i  (slice_a),
        .b_i  (slice_b),
        .gt_o (slice_gt),
        .lt_o (slice_lt)
    );

    // State and datapath registers
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            casc_q  <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            casc_q  <= casc_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        casc_d  = casc_q;
        data_d  = data_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.iStart) begin
                    // Offset-binary: flipping both MSBs makes unsigned slice
                    // compares order two's-complement values correctly.
                    a_d     = bus.iData_a ^ (bus.iSigned ? MSB_MASK : '0);
                    b_d     = bus.iData_b ^ (bus.iSigned ? MSB_MASK : '0);
                    casc_d  = bus.iData;
                    cnt_d   = CNT_W'(NSL - 1);
                    busy_d  = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (slice_gt || slice_lt) begin
                    data_d  = slice_gt ? CMP_GT : CMP_LT;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else if (cnt_q == '0) begin
                    data_d  = resolve_cascade(casc_q);
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign bus.oData = data_q;
    assign bus.oBusy = busy_q;
    assign bus.oDone = done_q;

endmodule

// File: tb/tb_data_compare_seq.sv
// Self-checking bench for data_compare_seq (WIDTH=16, SLICE=4).
module tb_data_compare_seq;

    typedef struct {
        logic [2:0] data;
        int         lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    data_compare_seq_if #(.WIDTH(16)) bus ();

    data_compare_seq #(.WIDTH(16), .SLICE(4)) dut (
        .iClk   (clk),
        .iRst_n (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Reference: true magnitude compare, cascade used only on equality
    function automatic logic [2:0] model_data(input logic [15:0] a, input logic [15:0] b,
                                              input logic s, input logic [2:0] c);
        logic gt, lt;
        gt = s ? ($signed(a) > $signed(b)) : (a > b);
        lt = s ? ($signed(a) < $signed(b)) : (a < b);
        if (gt) return 3'b100;
        if (lt) return 3'b001;
        if (c[1] || c == 3'b000) return 3'b010;
        if (c[2]) return 3'b100;
        return 3'b001;
    endfunction

    // Reference: 1-based index of the first differing nibble from the MSB
    function automatic int model_lat(input logic [15:0] a, input logic [15:0] b);
        for (int k = 1; k <= 4; k++) begin
            if (a[(4 - k) * 4 +: 4] != b[(4 - k) * 4 +: 4]) return k;
        end
        return 4;
    endfunction

    // Drives one start pulse and waits (bounded) for the done pulse.
    task automatic run_cmp(input logic [15:0] a, input logic [15:0] b, input logic s,
                           input logic [2:0] c, output logic [2:0] got, output int lat,
                           output int busy_cnt, output logic busy_end, output logic fell);
        @(negedge clk);
        bus.iStart  = 1'b1;
        bus.iSigned = s;
        bus.iData_a = a;
        bus.iData_b = b;
        bus.iData   = c;
        @(posedge clk); #1;
        bus.iStart = 1'b0;
        lat = 0;
        busy_cnt = 0;
        while (lat < 40 && bus.oDone !== 1'b1) begin
            if (bus.oBusy === 1'b1) busy_cnt++;
            @(posedge clk); #1;
            lat++;
        end
        got      = bus.oData;
        busy_end = bus.oBusy;
        @(posedge clk); #1;
        fell = (bus.oDone === 1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.iStart = 1'b0; bus.iSigned = 1'b0;
        bus.iData_a = '0; bus.iData_b = '0; bus.iData = '0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (bus.oData !== 3'b000) begin bad++; $display("FAIL reset_data: got %b expected 000", bus.oData); end
        total++; if (bus.oBusy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", bus.oBusy); end
        total++; if (bus.oDone !== 1'b0) begin bad++; $display("FAIL reset_done: got %b expected 0", bus.oDone); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_equal();
        logic [2:0] got; int lat, bc; logic be, fl; exp_t e;
        sb.push_back('{3'b010, 4});
        run_cmp(16'hA5A5, 16'hA5A5, 1'b0, 3'b010, got, lat, bc, be, fl);
        e = sb.pop_front();
        total++; if (got !== e.data) begin bad++; $display("FAIL equal_data: got %b expected %b", got, e.data); end
        total++; if (lat != e.lat) begin bad++; $display("FAIL equal_latency: got %0d expected %0d", lat, e.lat); end
        total++; if (bc != 4) begin bad++; $display("FAIL equal_busy_cycles: got %0d expected 4", bc); end
        total++; if (be !== 1'b0) begin bad++; $display("FAIL equal_busy_at_done: got %b expected 0", be); end
        total++; if (fl !== 1'b1) begin bad++; $display("FAIL equal_done_pulse: got %b expected 1", fl); end
    endtask

    task automatic test_early_exit();
        logic [15:0] ta[2] = '{16'hB000, 16'h1234};
        logic [15:0] tb[2] = '{16'hA000, 16'h1235};
        logic [2:0] got; int lat, bc; logic be, fl; exp_t e;
        sb.push_back('{3'b100, 1});
        sb.push_back('{3'b001, 4});
        for (int i = 0; i < 2; i++) begin
            run_cmp(ta[i], tb[i], 1'b0, 3'b010, got, lat, bc, be, fl);
            e = sb.pop_front();
            total++; if (got !== e.data) begin bad++; $display("FAIL early_data[%0d]: got %b expected %b", i, got, e.data); end
            total++; if (lat != e.lat) begin bad++; $display("FAIL early_latency[%0d]: got %0d expected %0d", i, lat, e.lat); end
        end
    endtask

    task automatic test_signed();
        logic [15:0] ta[3] = '{16'h8000, 16'h8000, 16'hFFFF};
        logic [15:0] tb[3] = '{16'h0001, 16'h0001, 16'hFFFE};
        logic        ts[3] = '{1'b1, 1'b0, 1'b1};
        logic [2:0] got; int lat, bc; logic be, fl; exp_t e;
        sb.push_back('{3'b001, 1});
        sb.push_back('{3'b100, 1});
        sb.push_back('{3'b100, 4});
        for (int i = 0; i < 3; i++) begin
            run_cmp(ta[i], tb[i], ts[i], 3'b010, got, lat, bc, be, fl);
            e = sb.pop_front();
            total++; if (got !== e.data) begin bad++; $display("FAIL signed_data[%0d]: got %b expected %b", i, got, e.data); end
            total++; if (lat != e.lat) begin bad++; $display("FAIL signed_latency[%0d]: got %0d expected %0d", i, lat, e.lat); end
        end
    endtask

    task automatic test_cascade();
        logic [2:0] tc[4] = '{3'b100, 3'b001, 3'b000, 3'b111};
        logic [2:0] te[4] = '{3'b100, 3'b001, 3'b010, 3'b010};
        logic [2:0] got; int lat, bc; logic be, fl; exp_t e;
        for (int i = 0; i < 4; i++) begin
            sb.push_back('{te[i], 4});
            run_cmp(16'h0F0F, 16'h0F0F, 1'b0, tc[i], got, lat, bc, be, fl);
            e = sb.pop_front();
            total++; if (got !== e.data) begin bad++; $display("FAIL cascade_data[%0d]: got %b expected %b", i, got, e.data); end
            total++; if (lat != e.lat) begin bad++; $display("FAIL cascade_latency[%0d]: got %0d expected %0d", i, lat, e.lat); end
        end
    endtask

    // iStart held high throughout; operands scrambled during RUN and DONE,
    // then a second request is presented for the first IDLE edge.
    task automatic test_handshake();
        int n, first, second; logic [2:0] d1, d2; exp_t e;
        sb.push_back('{3'b001, 4});
        sb.push_back('{3'b100, 4});
        @(negedge clk);
        bus.iStart = 1'b1; bus.iSigned = 1'b0;
        bus.iData_a = 16'h1234; bus.iData_b = 16'h1235; bus.iData = 3'b010;
        @(posedge clk); #1;
        n = 0; first = -1; second = -1; d1 = '0; d2 = '0;
        while (n < 40 && second < 0) begin
            @(negedge clk);
            if (first < 0 || n <= first) begin
                bus.iData_a = 16'($urandom); bus.iData_b = 16'($urandom);
                bus.iSigned = 1'($urandom);  bus.iData   = 3'($urandom);
            end else if (n == first + 1) begin
                bus.iData_a = 16'h0002; bus.iData_b = 16'h0001;
                bus.iSigned = 1'b0;     bus.iData   = 3'b010;
            end else begin
                bus.iStart = 1'b0;
            end
            @(posedge clk); #1;
            n++;
            if (bus.oDone === 1'b1) begin
                if (first < 0) begin first = n; d1 = bus.oData; end
                else begin second = n; d2 = bus.oData; end
            end
        end
        bus.iStart = 1'b0;
        e = sb.pop_front();
        total++; if (d1 !== e.data) begin bad++; $display("FAIL hs_first_data: got %b expected %b", d1, e.data); end
        total++; if (first != e.lat) begin bad++; $display("FAIL hs_first_latency: got %0d expected %0d", first, e.lat); end
        e = sb.pop_front();
        total++; if (d2 !== e.data) begin bad++; $display("FAIL hs_second_data: got %b expected %b", d2, e.data); end
        total++; if (second - first != e.lat + 2) begin bad++; $display("FAIL hs_done_spacing: got %0d expected %0d", second - first, e.lat + 2); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [15:0] a, b; logic s; logic [2:0] c;
        logic [2:0] got; int lat, bc; logic be, fl; exp_t e;
        for (int i = 0; i < 10; i++) begin
            a = 16'($urandom);
            b = (i % 3 == 0) ? a : 16'($urandom);
            if (i % 4 == 1) b = {a[15:4], 4'($urandom)};
            s = 1'($urandom);
            c = 3'($urandom);
            sb.push_back('{model_data(a, b, s, c), model_lat(a, b)});
            run_cmp(a, b, s, c, got, lat, bc, be, fl);
            e = sb.pop_front();
            total++; if (got !== e.data) begin bad++; $display("FAIL b2b_data[%0d] a=%h b=%h s=%b c=%b: got %b expected %b", i, a, b, s, c, got, e.data); end
            total++; if (lat != e.lat) begin bad++; $display("FAIL b2b_latency[%0d]: got %0d expected %0d", i, lat, e.lat); end
            total++; if (fl !== 1'b1) begin bad++; $display("FAIL b2b_done_pulse[%0d]: got %b expected 1", i, fl); end
        end
    endtask

    task automatic test_reset_mid();
        logic seen; logic [2:0] got; int lat, bc; logic be, fl; exp_t e;
        @(negedge clk);
        bus.iStart = 1'b1; bus.iSigned = 1'b0;
        bus.iData_a = 16'hA5A5; bus.iData_b = 16'hA5A5; bus.iData = 3'b100;
        @(posedge clk); #1;
        bus.iStart = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        total++; if (bus.oData !== 3'b000) begin bad++; $display("FAIL rstmid_data: got %b expected 000", bus.oData); end
        total++; if (bus.oBusy !== 1'b0) begin bad++; $display("FAIL rstmid_busy: got %b expected 0", bus.oBusy); end
        total++; if (bus.oDone !== 1'b0) begin bad++; $display("FAIL rstmid_done: got %b expected 0", bus.oDone); end
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (bus.oDone !== 1'b0) seen = 1'b1;
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (bus.oDone !== 1'b0 || bus.oBusy !== 1'b0) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL rstmid_no_done: got %b expected 0", seen); end
        sb.push_back('{3'b100, 4});
        run_cmp(16'h0002, 16'h0001, 1'b0, 3'b010, got, lat, bc, be, fl);
        e = sb.pop_front();
        total++; if (got !== e.data) begin bad++; $display("FAIL rstmid_after_data: got %b expected %b", got, e.data); end
        total++; if (lat != e.lat) begin bad++; $display("FAIL rstmid_after_latency: got %0d expected %0d", lat, e.lat); end
    endtask

    initial begin
        test_reset();
        test_equal();
        test_early_exit();
        test_signed();
        test_cascade();
        test_handshake();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
